// File: rtl/atomic_request_unit.sv
// atomic_request_unit
// Turns per-instruction memory intent from the control unit into held
// iREN/dREN/dWEN requests toward the caches, and owns the LL/SC link
// register (set by LL, consumed by SC, cleared by matching stores/snoops).
//
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   ihit, dhit           instruction / data access completed this cycle
//   mem_read, mem_write  current instruction loads / stores
//   datomic              current load/store is LL/SC
//   halt                 current instruction is HALT
//   daddr                effective data address
//   snoop_valid/_addr    coherence invalidation observed this cycle
//   iREN, dREN, dWEN     cache requests (registered)
//   sc_done, sc_result   one-cycle SC outcome pulse and held result
//   link_valid/_addr     LL reservation state
module atomic_request_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              datomic,
  input  logic              halt,
  input  logic [ADDR_W-1:0] daddr,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              sc_done,
  output logic              sc_result,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DBUSY  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Link comparisons are word granular: the byte offset is ignored.
  function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

  state_t              r_state, w_state_nxt;
  logic                r_iren, w_iren_nxt;
  logic                r_dren, w_dren_nxt;
  logic                r_dwen, w_dwen_nxt;
  logic                r_sc_done, w_sc_done_nxt;
  logic                r_sc_result, w_sc_result_nxt;
  logic                r_link_valid, w_link_valid_nxt;
  logic [ADDR_W-1:0]   r_link_addr, w_link_addr_nxt;
  // Operation in flight while in DBUSY; address latched at issue so a
  // changing daddr during the wait cannot corrupt the link update.
  logic                r_op_ll, w_op_ll_nxt;
  logic                r_op_sc, w_op_sc_nxt;
  logic [ADDR_W-1:0]   r_req_addr, w_req_addr_nxt;

  logic                w_snoop_hit;
  logic                w_sc_ok;

  assign w_snoop_hit = snoop_valid && word_match(snoop_addr, r_link_addr);
  // A snoop landing in the same cycle as SC issue kills the reservation first.
  assign w_sc_ok     = r_link_valid && word_match(r_link_addr, daddr) && !w_snoop_hit;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_dren_nxt       = r_dren;
    w_dwen_nxt       = r_dwen;
    w_sc_done_nxt    = 1'b0;
    w_sc_result_nxt  = r_sc_result;
    w_link_valid_nxt = r_link_valid && !w_snoop_hit;
    w_link_addr_nxt  = r_link_addr;
    w_op_ll_nxt      = r_op_ll;
    w_op_sc_nxt      = r_op_sc;
    w_req_addr_nxt   = r_req_addr;
    case (r_state)
      IDLE: begin
        if (ihit) begin
          if (halt) begin
            w_state_nxt = HALTED;
            w_dren_nxt  = 1'b0;
            w_dwen_nxt  = 1'b0;
          end else if (mem_read) begin
            w_state_nxt    = DBUSY;
            w_dren_nxt     = 1'b1;
            w_op_ll_nxt    = datomic;
            w_op_sc_nxt    = 1'b0;
            w_req_addr_nxt = daddr;
          end else if (mem_write && !datomic) begin
            w_state_nxt    = DBUSY;
            w_dwen_nxt     = 1'b1;
            w_op_ll_nxt    = 1'b0;
            w_op_sc_nxt    = 1'b0;
            w_req_addr_nxt = daddr;
          end else if (mem_write && w_sc_ok) begin
            w_state_nxt    = DBUSY;
            w_dwen_nxt     = 1'b1;
            w_op_ll_nxt    = 1'b0;
            w_op_sc_nxt    = 1'b1;
            w_req_addr_nxt = daddr;
          end else if (mem_write) begin
            // SC without a valid matching reservation fails immediately.
            w_sc_done_nxt   = 1'b1;
            w_sc_result_nxt = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DBUSY: begin
        if (dhit) begin
          w_state_nxt = IDLE;
          w_dren_nxt  = 1'b0;
          w_dwen_nxt  = 1'b0;
          if (r_op_ll) begin
            // LL set overrides a coincident snoop clear.
            w_link_valid_nxt = 1'b1;
            w_link_addr_nxt  = r_req_addr;
          end else if (r_op_sc) begin
            w_link_valid_nxt = 1'b0;
            w_sc_done_nxt    = 1'b1;
            w_sc_result_nxt  = 1'b1;
          end else if (r_dwen && word_match(r_req_addr, r_link_addr)) begin
            w_link_valid_nxt = 1'b0;
          end else begin
            w_link_addr_nxt = r_link_addr;
          end
        end else begin
          w_state_nxt = DBUSY;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
        w_dren_nxt  = 1'b0;
        w_dwen_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_dren_nxt  = 1'b0;
        w_dwen_nxt  = 1'b0;
      end
    endcase
    w_iren_nxt = (w_state_nxt == IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_iren       <= 1'b1;
      r_dren       <= 1'b0;
      r_dwen       <= 1'b0;
      r_sc_done    <= 1'b0;
      r_sc_result  <= 1'b0;
      r_link_valid <= 1'b0;
      r_link_addr  <= {ADDR_W{1'b0}};
      r_op_ll      <= 1'b0;
      r_op_sc      <= 1'b0;
      r_req_addr   <= {ADDR_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_iren       <= w_iren_nxt;
      r_dren       <= w_dren_nxt;
      r_dwen       <= w_dwen_nxt;
      r_sc_done    <= w_sc_done_nxt;
      r_sc_result  <= w_sc_result_nxt;
      r_link_valid <= w_link_valid_nxt;
      r_link_addr  <= w_link_addr_nxt;
      r_op_ll      <= w_op_ll_nxt;
      r_op_sc      <= w_op_sc_nxt;
      r_req_addr   <= w_req_addr_nxt;
    end
  end

  assign iREN       = r_iren;
  assign dREN       = r_dren;
  assign dWEN       = r_dwen;
  assign sc_done    = r_sc_done;
  assign sc_result  = r_sc_result;
  assign link_valid = r_link_valid;
  assign link_addr  = r_link_addr;

endmodule

// File: tb/tb_atomic_request_unit.sv
// Directed testbench for atomic_request_unit: reset, load, LL/SC success
// and failure, snoop invalidation, store link clearing, halt, and reset
// during an outstanding request.
module tb_atomic_request_unit;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, mem_read, mem_write, datomic, halt;
  logic [31:0] daddr, snoop_addr;
  logic        snoop_valid;
  logic        iREN, dREN, dWEN, sc_done, sc_result, link_valid;
  logic [31:0] link_addr;

  int errors = 0;
  int checks = 0;

  atomic_request_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_read(mem_read), .mem_write(mem_write), .datomic(datomic),
    .halt(halt), .daddr(daddr), .snoop_valid(snoop_valid),
    .snoop_addr(snoop_addr), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .sc_done(sc_done), .sc_result(sc_result), .link_valid(link_valid),
    .link_addr(link_addr)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction with ihit for a single cycle.
  task automatic issue(input logic rd, input logic wr, input logic at,
                       input logic [31:0] addr);
    ihit = 1'b1; mem_read = rd; mem_write = wr; datomic = at; daddr = addr;
    tick();
    ihit = 1'b0; mem_read = 1'b0; mem_write = 1'b0; datomic = 1'b0;
  endtask

  task automatic complete();
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    datomic = 1'b0; halt = 1'b0; daddr = 32'h0; snoop_valid = 1'b0; snoop_addr = 32'h0;
    tick(); tick();
    nRST = 1'b1;
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL reset_iren got %b exp 1", iREN); end
    checks++; if ({dREN, dWEN, sc_done, sc_result, link_valid} !== 5'b00000) begin
      errors++; $display("FAIL reset_outs got %b exp 00000", {dREN, dWEN, sc_done, sc_result, link_valid}); end
    checks++; if (link_addr !== 32'h0) begin errors++; $display("FAIL reset_link_addr got %h exp 0", link_addr); end
  endtask

  task automatic test_load();
    issue(1'b1, 1'b0, 1'b0, 32'h100);
    checks++; if ({iREN, dREN, dWEN} !== 3'b010) begin errors++; $display("FAIL load_issue got %b exp 010", {iREN, dREN, dWEN}); end
    // ihit + store during DBUSY must be ignored
    ihit = 1'b1; mem_write = 1'b1; tick(); ihit = 1'b0; mem_write = 1'b0;
    tick(); tick();
    checks++; if ({iREN, dREN, dWEN} !== 3'b010) begin errors++; $display("FAIL load_hold got %b exp 010", {iREN, dREN, dWEN}); end
    complete();
    checks++; if ({iREN, dREN, dWEN} !== 3'b100) begin errors++; $display("FAIL load_done got %b exp 100", {iREN, dREN, dWEN}); end
    checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL load_no_link got %b exp 0", link_valid); end
    // dhit while idle is ignored
    complete();
    checks++; if ({iREN, dREN, dWEN} !== 3'b100) begin errors++; $display("FAIL idle_dhit got %b exp 100", {iREN, dREN, dWEN}); end
  endtask

  task automatic test_llsc_success();
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    complete();
    checks++; if (link_valid !== 1'b1) begin errors++; $display("FAIL ll_link_valid got %b exp 1", link_valid); end
    checks++; if (link_addr !== 32'h200) begin errors++; $display("FAIL ll_link_addr got %h exp 200", link_addr); end
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    checks++; if ({iREN, dWEN, sc_done} !== 3'b010) begin errors++; $display("FAIL sc_issue got %b exp 010", {iREN, dWEN, sc_done}); end
    complete();
    checks++; if ({sc_done, sc_result, link_valid, dWEN, iREN} !== 5'b11001) begin
      errors++; $display("FAIL sc_success got %b exp 11001", {sc_done, sc_result, link_valid, dWEN, iREN}); end
    tick();
    checks++; if ({sc_done, sc_result} !== 2'b01) begin errors++; $display("FAIL sc_pulse got %b exp 01", {sc_done, sc_result}); end
  endtask

  task automatic test_sc_fail_addr();
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    complete();
    issue(1'b0, 1'b1, 1'b1, 32'h204);
    checks++; if ({sc_done, sc_result, dWEN, iREN, link_valid} !== 5'b10011) begin
      errors++; $display("FAIL sc_fail_addr got %b exp 10011", {sc_done, sc_result, dWEN, iREN, link_valid}); end
    tick();
    checks++; if ({sc_done, dWEN, link_valid} !== 3'b001) begin errors++; $display("FAIL sc_fail_after got %b exp 001", {sc_done, dWEN, link_valid}); end
  endtask

  task automatic test_snoop();
    issue(1'b1, 1'b0, 1'b1, 32'h300);
    complete();
    snoop_valid = 1'b1; snoop_addr = 32'h302;
    tick();
    snoop_valid = 1'b0;
    checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL snoop_clear got %b exp 0", link_valid); end
    issue(1'b0, 1'b1, 1'b1, 32'h300);
    checks++; if ({sc_done, sc_result, dWEN} !== 3'b100) begin errors++; $display("FAIL sc_after_snoop got %b exp 100", {sc_done, sc_result, dWEN}); end
    // snoop coincident with SC issue
    issue(1'b1, 1'b0, 1'b1, 32'h300);
    complete();
    checks++; if (link_valid !== 1'b1) begin errors++; $display("FAIL relink got %b exp 1", link_valid); end
    snoop_valid = 1'b1; snoop_addr = 32'h300;
    issue(1'b0, 1'b1, 1'b1, 32'h300);
    snoop_valid = 1'b0;
    checks++; if ({sc_done, sc_result, dWEN, link_valid} !== 4'b1000) begin
      errors++; $display("FAIL sc_snoop_same got %b exp 1000", {sc_done, sc_result, dWEN, link_valid}); end
    // snoop coincident with LL completion: LL wins
    issue(1'b1, 1'b0, 1'b1, 32'h500);
    complete();
    issue(1'b1, 1'b0, 1'b1, 32'h500);
    snoop_valid = 1'b1; snoop_addr = 32'h500;
    complete();
    snoop_valid = 1'b0;
    checks++; if ({link_valid, link_addr} !== {1'b1, 32'h500}) begin
      errors++; $display("FAIL ll_vs_snoop got %b/%h exp 1/500", link_valid, link_addr); end
  endtask

  task automatic test_store_clear();
    issue(1'b1, 1'b0, 1'b1, 32'h400);
    complete();
    issue(1'b0, 1'b1, 1'b0, 32'h408);
    checks++; if (dWEN !== 1'b1) begin errors++; $display("FAIL store_dwen got %b exp 1", dWEN); end
    complete();
    checks++; if (link_valid !== 1'b1) begin errors++; $display("FAIL store_other got %b exp 1", link_valid); end
    issue(1'b0, 1'b1, 1'b0, 32'h401);
    complete();
    checks++; if ({link_valid, dWEN, iREN} !== 3'b001) begin errors++; $display("FAIL store_same got %b exp 001", {link_valid, dWEN, iREN}); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 32'h700);
    halt = 1'b0;
    checks++; if ({iREN, dREN, dWEN} !== 3'b000) begin errors++; $display("FAIL halt_enter got %b exp 000", {iREN, dREN, dWEN}); end
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 1'b0, 32'h700);
      dhit = 1'b1;
    end
    dhit = 1'b0;
    tick();
    checks++; if ({iREN, dREN, dWEN} !== 3'b000) begin errors++; $display("FAIL halt_stay got %b exp 000", {iREN, dREN, dWEN}); end
  endtask

  task automatic test_reset_dbusy();
    nRST = 1'b0; tick(); nRST = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 32'h600);
    checks++; if (dWEN !== 1'b1) begin errors++; $display("FAIL rst_busy_dwen got %b exp 1", dWEN); end
    nRST = 1'b0; tick(); nRST = 1'b1;
    checks++; if ({iREN, dWEN, link_valid} !== 3'b100) begin errors++; $display("FAIL rst_busy got %b exp 100", {iREN, dWEN, link_valid}); end
    checks++; if (link_addr !== 32'h0) begin errors++; $display("FAIL rst_busy_addr got %h exp 0", link_addr); end
    tick();
    checks++; if ({iREN, dREN, dWEN} !== 3'b100) begin errors++; $display("FAIL rst_busy_idle got %b exp 100", {iREN, dREN, dWEN}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_llsc_success();
    test_sc_fail_addr();
    test_snoop();
    test_store_clear();
    test_halt();
    test_reset_dbusy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atomic_request_unit.md
# atomic_request_unit

Memory request sequencer that consumes the decoded control signals (mem_read, mem_write, datomic, halt) produced by the control unit. It converts per-instruction memory intent into held iREN/dREN/dWEN requests toward the caches. It also owns the LL/SC link register, including invalidation from coherence snoops. It sits between the control unit and the datapath/cache boundary in the single-cycle and pipelined cores.

## Interface
Parameters:
- ADDR_W, 32, address width (word_t from cpu_types_pkg)

Ports:
- CLK  input  1  core clock
- nRST  input  1  synchronous, active-low reset
- ihit  input  1  instruction fetch completed this cycle
- dhit  input  1  data access completed this cycle
- mem_read  input  1  current instruction loads (control unit)
- mem_write  input  1  current instruction stores (control unit)
- datomic  input  1  current load/store is LL/SC (control unit)
- halt  input  1  current instruction is HALT (control unit)
- daddr  input  ADDR_W  effective data address of the current instruction
- snoop_valid  input  1  coherence invalidation observed this cycle
- snoop_addr  input  ADDR_W  address of the snoop invalidation
- iREN  output  1  instruction read request
- dREN  output  1  data read request, held until dhit
- dWEN  output  1  data write request, held until dhit
- sc_done  output  1  one-cycle pulse: SC outcome is valid
- sc_result  output  1  SC outcome (1 = success, 0 = fail), valid with sc_done
- link_valid  output  1  reservation held
- link_addr  output  ADDR_W  reserved address

## Operation
- States: IDLE, DBUSY, HALTED. Outputs are Moore/registered. iREN = (state == IDLE).
- Reset (nRST low at CLK edge): state IDLE; iREN 1, dREN 0, dWEN 0, sc_done 0, sc_result 0, link_valid 0, link_addr 0. Reset mid-DBUSY aborts the request with no link update.
- IDLE, ihit and halt: go to HALTED. Halt has priority over mem_read/mem_write.
- IDLE, ihit and mem_read: dREN <= 1, go to DBUSY.
- IDLE, ihit, mem_write and !datomic: dWEN <= 1, go to DBUSY.
- IDLE, ihit, mem_write and datomic (SC):
  - Success precondition: link_valid && link_addr[31:2] == daddr[31:2] && no matching snoop this cycle.
  - Precondition true: dWEN <= 1, go to DBUSY.
  - Precondition false: no dWEN. sc_done <= 1, sc_result <= 0. Stay in IDLE.
- IDLE, ihit and no memory op: stay in IDLE.
- IDLE, dhit: ignored.
- DBUSY: dREN/dWEN held, iREN 0, ihit ignored. On dhit: clear dREN/dWEN and go to IDLE. The completing operation sets the link as follows:
  - LL: link_valid <= 1, link_addr <= daddr.
  - SC: link_valid <= 0, sc_done <= 1, sc_result <= 1.
  - Plain store with daddr[31:2] == link_addr[31:2]: link_valid <= 0.
- Snoop rule: in any state, snoop_valid with snoop_addr[31:2] == link_addr[31:2] clears link_valid next cycle.
  - Snoop coincident with LL completion (same cycle): the LL set wins, and link_valid = 1.
  - Snoop coincident with SC issue in IDLE: the snoop wins, and the SC fails.
- HALTED: all requests 0, iREN 0. Only reset exits.
- sc_done is a single-cycle pulse. It is cleared the cycle after assertion. sc_result holds its last value.
- The lower 2 address bits are ignored in all link comparisons.

## Timing
- ihit at edge n with a load/store: dREN/dWEN = 1 from cycle n+1.
- dhit at edge m: dREN/dWEN = 0 and iREN = 1 from cycle m+1. sc_done pulses in cycle m+1.
- Minimum load/store turnaround: 2 cycles (dhit in the first DBUSY cycle).
- SC fail: ihit at n gives sc_done = 1, sc_result = 0 in cycle n+1. dWEN is never asserted, and iREN stays 1.
- Link set/clear takes effect in the cycle after the triggering edge.
- halt on ihit at n: iREN = 0 from n+1, permanently.

## Test plan
- Reset, then load: nRST low 2 cycles → iREN 1, others 0. ihit + mem_read, daddr 0x100 → dREN 1 next cycle. Hold 3 cycles, then dhit → dREN 0, iREN 1.
- LL/SC success: LL at 0x200 with dhit → link_valid 1, link_addr 0x200. SC at 0x200 → dWEN 1. After dhit → sc_done 1, sc_result 1, link_valid 0.
- SC fail, address mismatch: link at 0x200, SC at 0x204 → sc_done 1, sc_result 0, dWEN never 1, link_valid stays 1.
- Snoop invalidation: link at 0x300, snoop_valid with snoop_addr 0x302 → link_valid 0. A following SC to 0x300 fails. Also check a snoop in the same cycle as SC issue → SC fails.
- Plain store clears the link: link at 0x400, a non-atomic store to 0x400 completes → link_valid 0. A store to 0x408 instead leaves link_valid 1.
- Halt and reset during DBUSY:
  - ihit + halt + mem_read → HALTED, all requests 0 forever.
  - Separately, nRST low while dWEN is held → dWEN 0, state IDLE, link unchanged from its reset value of 0.
